// File: rtl/red_seq.sv
// ============================================================================
// Module   : red_seq
// Brief    : Multi-cycle RED (nibble-reduction) sequencer. One shared 7-bit
//            accumulate adder sums the eight nibbles of {op_b, op_a}.
// Revision : 1.0
// ============================================================================
`default_nettype none

module red_seq #(
    parameter int LANES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        flush,
    input  logic [15:0] op_a,
    input  logic [15:0] op_b,
    output logic        busy,
    output logic        done,
    output logic [15:0] result
);

    localparam int         c_n    = 8 / LANES;
    localparam logic [2:0] c_last = 3'(c_n - 1);

    localparam logic [1:0] c_idle  = 2'd0;
    localparam logic [1:0] c_accum = 2'd1;
    localparam logic [1:0] c_done  = 2'd2;

    logic [1:0]  r_state;
    logic [31:0] r_nib;
    logic [6:0]  r_acc;
    logic [2:0]  r_cnt;
    logic [15:0] r_result;

    logic [2:0]  w_nidx [LANES];
    logic [3:0]  w_lane [LANES];
    logic [6:0]  w_presum;
    logic [6:0]  w_acc_next;
    logic        w_accept;

    // Lane i of this cycle picks nibble cnt*LANES+i from the latched vector.
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        assign w_nidx[gi] = 3'(int'(r_cnt) * LANES + gi);
        assign w_lane[gi] = r_nib[{w_nidx[gi], 2'b00} +: 4];
    end

    always_comb begin
        w_presum = 7'd0;
        for (int i = 0; i < LANES; i++) begin
            w_presum = w_presum + {3'b000, w_lane[i]};
        end
    end

    assign w_acc_next = r_acc + w_presum;
    assign w_accept   = start && !flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= c_idle;
            r_nib    <= 32'h0;
            r_acc    <= 7'd0;
            r_cnt    <= 3'd0;
            r_result <= 16'h0000;
        end else begin
            case (r_state)
                c_idle, c_done: begin
                    if (w_accept) begin
                        r_nib   <= {op_b, op_a};
                        r_acc   <= 7'd0;
                        r_cnt   <= 3'd0;
                        r_state <= c_accum;
                    end else begin
                        r_state <= c_idle;
                    end
                end
                c_accum: begin
                    // A flush abandons the operation even on its final add.
                    if (flush) begin
                        r_state <= c_idle;
                    end else begin
                        r_acc <= w_acc_next;
                        r_cnt <= r_cnt + 3'd1;
                        if (r_cnt == c_last) begin
                            r_result <= {9'b0, w_acc_next};
                            r_state  <= c_done;
                        end
                    end
                end
                default: r_state <= c_idle;
            endcase
        end
    end

    assign busy   = (r_state == c_accum);
    assign done   = (r_state == c_done);
    assign result = r_result;

endmodule

`default_nettype wire

// File: tb/tb_red_seq.sv
// ============================================================================
// Module   : tb_red_seq
// Brief    : Scoreboard bench driving LANES=1/2/4 instances of red_seq with
//            shared directed and random stimulus.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_red_seq;

    typedef struct {
        logic [15:0] res;
        int          due;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        start;
    logic        flush;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic        busy_v   [3];
    logic        done_v   [3];
    logic [15:0] result_v [3];

    exp_t        sb       [3][$];
    int          left     [3];
    bit          done_exp [3];
    logic [15:0] last_res [3];
    int          cyc;
    bit          armed;
    int          n_checks;
    int          n_errors;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        red_seq #(.LANES(1 << g)) u_dut (
            .clk    (clk),
            .rst    (rst),
            .start  (start),
            .flush  (flush),
            .op_a   (op_a),
            .op_b   (op_b),
            .busy   (busy_v[g]),
            .done   (done_v[g]),
            .result (result_v[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] nib_sum(input logic [15:0] a, input logic [15:0] b);
        logic [31:0] v;
        int s;
        v = {b, a};
        s = 0;
        for (int i = 0; i < 8; i++) s += int'((v >> (4 * i)) & 32'hF);
        return 16'(s);
    endfunction

    task automatic check(input bit ok, input string name, input int k,
                         input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (!ok) begin
            n_errors++;
            $display("FAIL %s lanes=%0d cyc=%0d actual=%h required=%h", name, 1 << k, cyc, act, exp);
        end
    endtask

    // Reference model: occupancy counters per instance, expectations queued on acceptance.
    always @(posedge clk) begin
        cyc++;
        for (int k = 0; k < 3; k++) begin
            if (rst) begin
                left[k]     = 0;
                done_exp[k] = 1'b0;
                last_res[k] = 16'h0000;
                sb[k].delete();
                armed       = 1'b1;
            end else begin
                done_exp[k] = 1'b0;
                if (left[k] > 0) begin
                    if (flush) begin
                        left[k] = 0;
                        if (sb[k].size() > 0) void'(sb[k].pop_back());
                    end else begin
                        left[k]--;
                        if (left[k] == 0) begin
                            done_exp[k] = 1'b1;
                            if (sb[k].size() > 0) last_res[k] = sb[k][0].res;
                        end
                    end
                end else if (start && !flush) begin
                    left[k] = 8 >> k;
                    sb[k].push_back('{res: nib_sum(op_a, op_b), due: cyc + (8 >> k)});
                end
            end
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (armed) begin
                for (int k = 0; k < 3; k++) begin
                    check(busy_v[k] === (left[k] > 0), "busy", k, 16'(busy_v[k]), 16'(left[k] > 0));
                    check(done_v[k] === done_exp[k], "done", k, 16'(done_v[k]), 16'(done_exp[k]));
                    check(!(busy_v[k] && done_v[k]), "busy_done_excl", k, 16'(busy_v[k]), 16'h0);
                    check(result_v[k] === last_res[k], "result_hold", k, result_v[k], last_res[k]);
                    if (done_v[k] === 1'b1) begin
                        if (sb[k].size() == 0) begin
                            check(1'b0, "unexpected_done", k, 16'h1, 16'h0);
                        end else begin
                            e = sb[k].pop_front();
                            check(e.due == cyc, "latency", k, 16'(cyc), 16'(e.due));
                            check(result_v[k] === e.res, "result", k, result_v[k], e.res);
                        end
                    end else if (sb[k].size() > 0 && sb[k][0].due < cyc) begin
                        e = sb[k].pop_front();
                        check(1'b0, "done_timeout", k, 16'(cyc), 16'(e.due));
                    end
                end
            end
        end
    end

    task automatic drive(input bit s, input bit f, input bit r,
                         input logic [15:0] a, input logic [15:0] b);
        @(negedge clk);
        start = s;
        flush = f;
        rst   = r;
        op_a  = a;
        op_b  = b;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    endtask

    function automatic logic [15:0] rand_op();
        case ($urandom_range(0, 5))
            0:       return 16'h0000;
            1:       return 16'hFFFF;
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        n_checks = 0;
        n_errors = 0;
        cyc      = 0;
        armed    = 1'b0;
        rst      = 1'b1;
        start    = 1'b0;
        flush    = 1'b0;
        op_a     = 16'h0;
        op_b     = 16'h0;
        drive(1'b0, 1'b0, 1'b1, 16'h0, 16'h0);
        drive(1'b0, 1'b0, 1'b1, 16'h0, 16'h0);
        idle(2);

        drive(1'b1, 1'b0, 1'b0, 16'h1234, 16'h5678);
        idle(12);
        drive(1'b1, 1'b0, 1'b0, 16'hFFFF, 16'hFFFF);
        idle(12);
        drive(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
        idle(12);

        // start held high: ignored in ACCUM, re-accepted in the DONE cycle
        drive(1'b1, 1'b0, 1'b0, 16'h1111, 16'h1111);
        repeat (8) drive(1'b1, 1'b0, 1'b0, 16'h1111, 16'h1111);
        repeat (9) drive(1'b1, 1'b0, 1'b0, 16'hF0F0, 16'h0F0F);
        idle(12);

        drive(1'b1, 1'b0, 1'b0, 16'hABCD, 16'h1357);
        idle(3);
        drive(1'b0, 1'b1, 1'b0, 16'h0, 16'h0);
        idle(3);
        drive(1'b1, 1'b0, 1'b0, 16'h000F, 16'h0000);
        idle(12);

        drive(1'b1, 1'b0, 1'b0, 16'h9999, 16'h7777);
        idle(3);
        drive(1'b0, 1'b0, 1'b1, 16'h0, 16'h0);
        idle(4);
        drive(1'b1, 1'b1, 1'b0, 16'h4444, 16'h4444);
        idle(12);

        for (int i = 0; i < 1200; i++) begin
            drive($urandom_range(0, 1) == 1, $urandom_range(0, 15) == 0,
                  $urandom_range(0, 99) == 0, rand_op(), rand_op());
        end
        idle(20);

        for (int k = 0; k < 3; k++) begin
            check(sb[k].size() == 0, "drain", k, 16'(sb[k].size()), 16'h0);
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/red_seq.md
Name: red_seq

Overview:
Multi-cycle sequencer for the RED (nibble-reduction) operation. It time-multiplexes one shared narrow accumulate adder across the eight source nibbles instead of using a full combinational adder tree. It sits in the EX stage beside the ALU: the decoder pulses start, and the sequencer stalls the pipeline (busy) until the reduction completes (done). The reduction is an unsigned sum of all 4-bit nibbles of op_a and op_b, zero-extended to 16 bits.

Parameters:
LANES, 1, nibbles summed per accumulate cycle; legal values are 1, 2 or 4; accumulate cycles N = 8/LANES.

Ports:
clk  in  1  system clock; all state changes on the rising edge
rst  in  1  synchronous, active-high reset
start  in  1  request a RED on op_a/op_b; sampled only in IDLE or DONE
flush  in  1  pipeline flush; abort any in-flight operation
op_a  in  16  source operand A (nibbles a0..a3, a0 = bits 3:0)
op_b  in  16  source operand B (nibbles b0..b3)
busy  out  1  high while in ACCUM; drives the pipeline stall
done  out  1  one-cycle pulse; result valid this cycle
result  out  16  zero-extended 7-bit nibble sum; held until next completion

Behaviour:
- Reset (rst=1 at a clock edge; overrides everything): state=IDLE, busy=0, done=0, result=16'h0000, accumulator=0, counter=0, operand latches=0.
- States: IDLE, ACCUM, DONE.
- IDLE: if start && !flush -> latch {op_b,op_a} as an 8-nibble vector n0..n7 (n0=a0 ... n3=a3, n4=b0 ... n7=b3), acc<=0, cnt<=0, go to ACCUM. Otherwise stay in IDLE.
- ACCUM: busy=1. Each cycle acc <= acc + sum of nibbles n[cnt*LANES .. cnt*LANES+LANES-1], each zero-extended; cnt <= cnt+1.
  - On the cycle where cnt == N-1: perform the final add, write result <= {9'b0, acc_next[6:0]}, go to DONE.
  - start is ignored in ACCUM; operand inputs are don't-care after latching.
- DONE: done=1 for exactly one cycle; busy=0. If start && !flush, accept a new operation exactly as from IDLE (back-to-back) and go to ACCUM; otherwise go to IDLE.
- flush: in ACCUM -> IDLE next cycle; no done pulse; result unchanged. In IDLE/DONE, flush suppresses start; done still pulses in DONE, since that operation already completed.
- Latency: start accepted at edge T -> done high during cycle T+N+1 (LANES=1: 9 cycles; LANES=2: 5; LANES=4: 3). Throughput is one op per N+1 cycles with back-to-back starts.
- Arithmetic: acc is 7 bits unsigned; the maximum is 8*15 = 120, so no overflow is possible. The shared adder is a single instance of width 7 with a LANES-input nibble pre-sum. There is no carry-in and no sign extension.
- result updates only on completion; it is stable in every other cycle.
- busy and done are never high together.
- rst asserted mid-ACCUM: return to the reset state immediately at that edge, with no done.

Test Plan:
- Reset, then start with op_a=16'h1234, op_b=16'h5678 (LANES=1) -> busy high for 8 cycles, done pulses at T+9, result=16'h0024.
- op_a=op_b=16'hFFFF -> result=16'h0078; op_a=op_b=16'h0000 -> result=16'h0000 with done still at T+9.
- Back-to-back: start 0x1111/0x1111 (result 0x0008), then assert start in its DONE cycle with 0xF0F0/0x0F0F -> second done exactly 9 cycles later, result=16'h003C; no idle bubble.
- flush asserted 4 cycles into ACCUM -> state IDLE, no done, result keeps its previous value. Then start 0x000F/0x0000 -> result=16'h000F.
- rst asserted mid-ACCUM -> next cycle busy=0, done=0, result=16'h0000. Also: start held continuously during ACCUM does not restart the operation.
- Rebuild with LANES=2 and LANES=4, run op_a=16'h1234, op_b=16'h5678 -> done at T+5 and T+3 respectively, result=16'h0024 in both cases.
